// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and grant_id codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_LOAD = 2'd1;
  localparam logic [1:0] GNT_IM   = 2'd2;
  localparam logic [1:0] GNT_DM   = 2'd3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: load always wins; a dm/im tie is broken by rr_ptr
// (0 = dm, 1 = im). A lone requester wins regardless of rr_ptr.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       load_req,
  input  logic       dm_req,
  input  logic       im_req,
  input  logic       rr_ptr,
  output logic [1:0] pick_id
);

  always_comb begin
    pick_id = GNT_NONE;
    if (load_req)
      pick_id = GNT_LOAD;
    else if (dm_req && im_req)
      pick_id = rr_ptr ? GNT_IM : GNT_DM;
    else if (dm_req)
      pick_id = GNT_DM;
    else if (im_req)
      pick_id = GNT_IM;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between loader, instruction fetch and data port.
// Define ARB_RR_EN to alternate dm/im on ties; otherwise fixed load > dm > im.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MemSize    = 10,
  parameter int DataSize   = 32,
  parameter int MemLatency = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_req,
  input  logic [MemSize-1:0]  load_addr,
  input  logic [DataSize-1:0] load_wdata,
  input  logic                im_req,
  input  logic [MemSize-1:0]  im_addr,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [MemSize-1:0]  dm_addr,
  input  logic [DataSize-1:0] dm_wdata,
  output logic                load_ack,
  output logic                im_ack,
  output logic                dm_ack,
  output logic [DataSize-1:0] im_rdata,
  output logic [DataSize-1:0] dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MemSize-1:0]  mem_addr,
  output logic [DataSize-1:0] mem_wdata,
  input  logic [DataSize-1:0] mem_rdata,
  output logic                busy,
  output logic [1:0]          grant_id,
  output arb_state_e          state_dbg
);

  // Handshake: req is a level held with its address/data until the one-cycle
  // ack; the requester drops req in the ack cycle, otherwise the next IDLE
  // cycle sees a fresh request. Dropping req mid-access does not cancel it.

  localparam int CntW = (MemLatency > 1) ? $clog2(MemLatency) : 1;

  arb_state_e          state;
  logic [CntW-1:0]     cnt;
  logic [1:0]          pick_id;
  logic                rr_ptr;
  logic [MemSize-1:0]  sel_addr;
  logic [DataSize-1:0] sel_wdata;
  logic                sel_we;

  assign state_dbg = state;

  mem_arb_pick u_pick (
    .load_req (load_req),
    .dm_req   (dm_req),
    .im_req   (im_req),
    .rr_ptr   (rr_ptr),
    .pick_id  (pick_id)
  );

`ifdef ARB_RR_EN
  // Pointer points at whichever of dm/im was not served last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rr_ptr <= 1'b0;
    else if (state == ST_IDLE) begin
      if (pick_id == GNT_DM)
        rr_ptr <= 1'b1;
      else if (pick_id == GNT_IM)
        rr_ptr <= 1'b0;
    end
  end
`else
  assign rr_ptr = 1'b0;
`endif

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    case (pick_id)
      GNT_LOAD: begin
        sel_addr  = load_addr;
        sel_wdata = load_wdata;
        sel_we    = 1'b1;
      end
      GNT_DM: begin
        sel_addr  = dm_addr;
        sel_wdata = dm_wdata;
        sel_we    = dm_we;
      end
      GNT_IM: sel_addr = im_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      grant_id  <= GNT_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      load_ack  <= 1'b0;
      im_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      im_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      load_ack <= 1'b0;
      im_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_id != GNT_NONE) begin
            state     <= ST_ACCESS;
            grant_id  <= pick_id;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= CntW'(MemLatency - 1);
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            // Last access cycle: read data is valid now, ack shows up in DONE.
            state  <= ST_DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we && grant_id == GNT_IM)
              im_rdata <= mem_rdata;
            if (!mem_we && grant_id == GNT_DM)
              dm_rdata <= mem_rdata;
            load_ack <= (grant_id == GNT_LOAD);
            im_ack   <= (grant_id == GNT_IM);
            dm_ack   <= (grant_id == GNT_DM);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          grant_id <= GNT_NONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-timing reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MemSize    = 10;
  localparam int DataSize   = 32;
  localparam int MemLatency = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic                load_req, im_req, dm_req, dm_we;
  logic [MemSize-1:0]  load_addr, im_addr, dm_addr;
  logic [DataSize-1:0] load_wdata, dm_wdata;
  logic                load_ack, im_ack, dm_ack;
  logic [DataSize-1:0] im_rdata, dm_rdata;
  logic                mem_en, mem_we;
  logic [MemSize-1:0]  mem_addr;
  logic [DataSize-1:0] mem_wdata, mem_rdata;
  logic                busy;
  logic [1:0]          grant_id;
  arb_state_e          state_dbg;

  mem_port_arbiter #(.MemSize(MemSize), .DataSize(DataSize), .MemLatency(MemLatency)) dut (
    .clock(clock), .reset(reset),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .im_req(im_req), .im_addr(im_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .load_ack(load_ack), .im_ack(im_ack), .dm_ack(dm_ack),
    .im_rdata(im_rdata), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
  );

  // Memory macro seen by the DUT, and the model's view of what it should hold.
  logic [DataSize-1:0] mem_arr [0:1023];
  logic [DataSize-1:0] ref_mem [0:1023];
  assign mem_rdata = mem_en ? mem_arr[mem_addr] : '0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time: granted at edge m_g, memory busy for
  // MemLatency cycles, ack in the cycle after, next grant two cycles later.
  int                  cyc = 0;
  bit                  m_valid = 1'b0;
  int                  m_g = 0;
  logic [1:0]          m_win = GNT_NONE;
  logic [MemSize-1:0]  m_addr = '0;
  bit                  m_we = 1'b0;
  logic [DataSize-1:0] m_wdata = '0;
  logic [DataSize-1:0] exp_im_rd = '0, exp_dm_rd = '0;
  bit                  dm_turn = 1'b1;
  bit   [3:1]          just_acked = '0, want = '0;
  logic [1:0]          got_grants[$];
  bit                  prev_busy = 1'b0;
  int                  dm_ack_seen = 0, en_seen = 0, load_we_seen = 0, last_im_ack = 0;

  function automatic bit model_active();
    return m_valid && (cyc <= m_g + MemLatency);
  endfunction

  function automatic bit inflight(input logic [1:0] r);
    return model_active() && (m_win == r);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; exp_im_rd = '0; exp_dm_rd = '0;
    dm_turn = 1'b1; just_acked = '0; prev_busy = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit rand_mode);
    bit act, en, ack;
    logic [7:0] got_ctl, exp_ctl;
    arb_state_e exp_st;
    @(negedge clock);
    cyc++;
    if (!reset && (!m_valid || cyc >= m_g + MemLatency + 2) && (load_req || im_req || dm_req)) begin
      m_valid = 1'b1;
      m_g     = cyc;
      if (load_req) begin
        m_win = GNT_LOAD; m_addr = load_addr; m_we = 1'b1; m_wdata = load_wdata;
      end else if (dm_req && (!im_req || dm_turn)) begin
        m_win = GNT_DM; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
      end else begin
        m_win = GNT_IM; m_addr = im_addr; m_we = 1'b0; m_wdata = '0;
      end
`ifdef ARB_RR_EN
      if (m_win == GNT_DM) dm_turn = 1'b0;
      else if (m_win == GNT_IM) dm_turn = 1'b1;
`endif
    end
    act = model_active();
    en  = act && (cyc < m_g + MemLatency);
    ack = act && (cyc == m_g + MemLatency);
    if (ack) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else if (m_win == GNT_IM) exp_im_rd = ref_mem[m_addr];
      else exp_dm_rd = ref_mem[m_addr];
    end
    exp_st  = en ? ST_ACCESS : (ack ? ST_DONE : ST_IDLE);
    exp_ctl = {ack && m_win == GNT_LOAD, ack && m_win == GNT_IM, ack && m_win == GNT_DM,
               en, en && m_we, act, act ? m_win : GNT_NONE};
    got_ctl = {load_ack, im_ack, dm_ack, mem_en, mem_we, busy, grant_id};
    check_eq("ctl", got_ctl, exp_ctl);
    check_eq("state", state_dbg, exp_st);
    if (en) check_eq("addr", mem_addr, m_addr);
    if (en && m_we) check_eq("wdata", mem_wdata, m_wdata);
    check_eq("rdata", {im_rdata, dm_rdata}, {exp_im_rd, exp_dm_rd});
    if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    // Observation counters used by directed checks.
    if (busy && !prev_busy) got_grants.push_back(grant_id);
    prev_busy = busy;
    if (dm_ack) dm_ack_seen++;
    if (im_ack) last_im_ack = cyc;
    if (mem_en) en_seen++;
    if (mem_en && mem_we && grant_id == GNT_LOAD) load_we_seen++;
    // Requesters drop req in their ack cycle.
    just_acked = '0;
    if (ack) begin
      just_acked[m_win] = 1'b1;
      if (m_win == GNT_LOAD) load_req = 1'b0;
      else if (m_win == GNT_IM) im_req = 1'b0;
      else dm_req = 1'b0;
    end
    // New requests (held wants or random), never while the previous is in flight.
    if (!load_req && !inflight(GNT_LOAD) && !just_acked[1] &&
        (want[1] || (rand_mode && $urandom_range(0, 3) == 0))) begin
      if (rand_mode) begin
        load_addr = 10'($urandom_range(0, 15)); load_wdata = $urandom;
      end
      load_req = 1'b1;
    end
    if (!im_req && !inflight(GNT_IM) && !just_acked[2] &&
        (want[2] || (rand_mode && $urandom_range(0, 2) == 0))) begin
      if (rand_mode) im_addr = 10'($urandom_range(0, 15));
      im_req = 1'b1;
    end
    if (!dm_req && !inflight(GNT_DM) && !just_acked[3] &&
        (want[3] || (rand_mode && $urandom_range(0, 2) == 0))) begin
      if (rand_mode) begin
        dm_addr = 10'($urandom_range(0, 15)); dm_wdata = $urandom;
        dm_we = 1'($urandom_range(0, 1));
      end
      dm_req = 1'b1;
    end
    // Occasionally abandon a request that is already being served.
    if (rand_mode && !ack && $urandom_range(0, 3) == 0) begin
      if (inflight(GNT_LOAD)) load_req = 1'b0;
      if (inflight(GNT_IM)) im_req = 1'b0;
      if (inflight(GNT_DM)) dm_req = 1'b0;
    end
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    want = '0;
    while ((load_req || im_req || dm_req || model_active()) && k < max_cyc) begin
      step(1'b0);
      k++;
    end
    check_eq("drain_idle", {load_req, im_req, dm_req, model_active()}, 4'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] exp_order [3];
  int         t0;

  initial begin
    reset = 1'b1;
    load_req = 1'b0; im_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    load_addr = '0; im_addr = '0; dm_addr = '0; load_wdata = '0; dm_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    #2;
    check_eq("rst_out", {load_ack, im_ack, dm_ack, mem_en, mem_we, busy, grant_id, mem_addr,
                         state_dbg}, '0);
    check_eq("rst_data", {mem_wdata, im_rdata | dm_rdata}, '0);
    repeat (2) step(1'b0);
    reset = 1'b0;
    repeat (10) step(1'b0);

    // Single instruction fetch returning DEADBEEF.
    mem_arr[10'h21] = 32'hDEADBEEF;
    ref_mem[10'h21] = 32'hDEADBEEF;
    im_addr = 10'h21;
    im_req  = 1'b1;
    t0 = cyc + 1;
    en_seen = 0;
    drain(20);
    check_eq("im_en_cycles", en_seen, MemLatency);
    check_eq("im_ack_lat", last_im_ack - t0, MemLatency);
    check_eq("im_rdata", im_rdata, 32'hDEADBEEF);

    // dm and im held together.
    got_grants.delete();
    dm_we = 1'b0; dm_addr = 10'h3; im_addr = 10'h4;
    want = 3'b110;
    dm_req = 1'b1; im_req = 1'b1;
    for (int k = 0; k < 60 && got_grants.size() < 3; k++) step(1'b0);
    drain(40);
`ifdef ARB_RR_EN
    exp_order = '{GNT_DM, GNT_IM, GNT_DM};
`else
    exp_order = '{GNT_DM, GNT_DM, GNT_DM};
`endif
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("order%0d", i), (got_grants.size() > i) ? got_grants[i] : GNT_NONE,
               exp_order[i]);

    // All three together: load wins and writes 1 to 7F; dm then reads it back.
    got_grants.delete();
    load_addr = 10'h7F; load_wdata = 32'h1;
    dm_we = 1'b0; dm_addr = 10'h7F; im_addr = 10'h2;
    load_we_seen = 0;
    load_req = 1'b1; dm_req = 1'b1; im_req = 1'b1;
    drain(40);
    check_eq("first_load", (got_grants.size() > 0) ? got_grants[0] : GNT_NONE, GNT_LOAD);
    check_eq("load_we_cycles", load_we_seen, MemLatency);
    check_eq("dm_read_7f", dm_rdata, 32'h1);

    // Reset in the first ACCESS cycle of a dm write.
    dm_we = 1'b1; dm_addr = 10'h5; dm_wdata = 32'hCAFE0005;
    dm_req = 1'b1;
    @(posedge clock);
    #1;
    check_eq("pre_rst_en", {mem_en, grant_id}, {1'b1, GNT_DM});
    reset  = 1'b1;
    dm_req = 1'b0;
    #1;
    check_eq("rst_mid", {mem_en, mem_we, busy, grant_id, dm_ack}, '0);
    check_eq("rst_mid_data", {im_rdata, dm_rdata}, '0);
    model_reset();
    step(1'b0);
    reset = 1'b0;
    dm_ack_seen = 0;
    repeat (5) step(1'b0);
    check_eq("rst_no_ack", dm_ack_seen, 0);
    check_eq("rst_no_write", mem_arr[5], ref_mem[5]);

    // dm read dropped mid-access still completes once.
    dm_we = 1'b0; dm_addr = 10'h7F;
    dm_ack_seen = 0;
    dm_req = 1'b1;
    step(1'b0);
    dm_req = 1'b0;
    drain(20);
    check_eq("drop_ack_once", dm_ack_seen, 1);
    check_eq("drop_rdata", dm_rdata, 32'h1);

    // Random traffic.
    repeat (1500) step(1'b1);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
